// File: rtl/i2c_xfer_ctrl_pkg.sv
// Command encodings, FSM state codes and the step -> (cmd, din) decode shared
// by the I2C transaction sequencer.
package i2c_xfer_ctrl_pkg;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  localparam logic I2C_W = 1'b0;
  localparam logic I2C_R = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] WR_STOP_STEP = 3'd4;
  localparam logic [2:0] RD_STOP_STEP = 3'd6;
  localparam logic [2:0] RD_ADDR_STEP = 3'd4;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] din;
  } step_cmd_t;

  // Unlisted steps fall through to STOP, which covers the last step of both sequences.
  function automatic step_cmd_t step_decode(input logic       rw,
                                            input logic [2:0] step,
                                            input logic [6:0] dev,
                                            input logic [7:0] rg,
                                            input logic [7:0] wd);
    step_cmd_t sc;
    sc.cmd = CMD_STOP;
    sc.din = 8'h00;
    case (step)
      3'd0: sc.cmd = CMD_START;
      3'd1: begin sc.cmd = CMD_WR; sc.din = {dev, I2C_W}; end
      3'd2: begin sc.cmd = CMD_WR; sc.din = rg; end
      3'd3: begin
        if (rw) sc.cmd = CMD_RESTART;
        else begin sc.cmd = CMD_WR; sc.din = wd; end
      end
      3'd4: if (rw) begin sc.cmd = CMD_WR; sc.din = {dev, I2C_R}; end
      3'd5: begin sc.cmd = CMD_RD; sc.din = 8'h01; end
      default: ;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/i2c_xfer_ctrl.sv
// Sequences one single-byte I2C register read/write into engine commands,
// checking slave ACKs and retrying the whole access on an address NACK.
module i2c_xfer_ctrl
  import i2c_xfer_ctrl_pkg::*;
#(
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done_tick,
  output logic       nack_err,
  output logic [7:0] rdata,
  input  logic       m_ready,
  input  logic       m_done_tick,
  input  logic       m_ack,
  input  logic [7:0] m_dout,
  output logic [2:0] m_cmd,
  output logic [7:0] m_din,
  output logic       m_wr
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  logic [2:0] state, step, retry;
  logic [1:0] wcnt;
  logic       rw_q, ack_q, restart_pend;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rd_stage;

  step_cmd_t  cur;
  logic [2:0] stop_step;
  logic       addr_step, step_done;

  always_comb begin
    cur       = step_decode(rw_q, step, dev_q, reg_q, wdata_q);
    stop_step = rw_q ? RD_STOP_STEP : WR_STOP_STEP;
    addr_step = (step == 3'd1) || (rw_q && step == RD_ADDR_STEP);
    // Byte commands finish on the engine's tick; bus conditions only once the
    // engine has had time to drop m_ready after the strobe and raise it again.
    if (m_cmd == CMD_WR || m_cmd == CMD_RD) step_done = m_done_tick;
    else                                    step_done = m_ready && (wcnt == 2'd2);
  end

  assign busy      = (state != ST_IDLE);
  assign done_tick = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      step         <= 3'd0;
      retry        <= 3'd0;
      wcnt         <= 2'd0;
      restart_pend <= 1'b0;
      ack_q        <= 1'b0;
      rw_q         <= 1'b0;
      dev_q        <= 7'h00;
      reg_q        <= 8'h00;
      wdata_q      <= 8'h00;
      rd_stage     <= 8'h00;
      nack_err     <= 1'b0;
      rdata        <= 8'h00;
      m_wr         <= 1'b0;
      m_cmd        <= CMD_STOP;
      m_din        <= 8'h00;
    end else begin
      m_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rw_q         <= rw;
            dev_q        <= dev_addr;
            reg_q        <= reg_addr;
            wdata_q      <= wdata;
            nack_err     <= 1'b0;
            retry        <= 3'd0;
            step         <= 3'd0;
            restart_pend <= 1'b0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_ready) begin
            m_wr  <= 1'b1;
            m_cmd <= cur.cmd;
            m_din <= cur.din;
            wcnt  <= 2'd0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
          if (step_done) begin
            ack_q <= m_ack;
            if (m_cmd == CMD_RD) rd_stage <= m_dout;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          state <= ST_ISSUE;
          if (m_cmd == CMD_WR && ack_q && addr_step) begin
            step <= stop_step;
            if (retry < RETRY_LIMIT) begin
              retry        <= retry + 3'd1;
              restart_pend <= 1'b1;
            end else begin
              nack_err <= 1'b1;
            end
          end else if (m_cmd == CMD_WR && ack_q) begin
            nack_err <= 1'b1;
            step     <= stop_step;
          end else if (step == stop_step) begin
            if (restart_pend) begin
              restart_pend <= 1'b0;
              step         <= 3'd0;
            end else begin
              // rdata must already be valid while done_tick is high.
              if (rw_q && !nack_err) rdata <= rd_stage;
              state <= ST_DONE;
            end
          end else begin
            step <= step + 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Bench for i2c_xfer_ctrl: behavioural engine/slave, table vectors, random transactions.
module tb_i2c_xfer_ctrl;

  localparam int MAXR = 2;
  localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3, C_RESTART = 3'd4;

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    int         nacks;
    bit         dnack;
    logic [7:0] rdv;
    int         exp_n;
    bit         exp_nack;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00, wdata = 8'h00;
  logic busy, done_tick, nack_err, m_wr;
  logic [7:0] rdata, m_din;
  logic [2:0] m_cmd;
  logic m_ready = 1'b1, m_done_tick = 1'b0, m_ack = 1'b0;
  logic [7:0] m_dout = 8'h00;

  int checks = 0;
  int errors = 0;

  i2c_xfer_ctrl #(.MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done_tick(done_tick),
    .nack_err(nack_err), .rdata(rdata), .m_ready(m_ready), .m_done_tick(m_done_tick),
    .m_ack(m_ack), .m_dout(m_dout), .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr)
  );

  always #5 clk = ~clk;

  // Slave configuration for the current transaction (set by the stimulus).
  int         cfg_nacks = 0;
  bit         cfg_dnack = 1'b0;
  logic [7:0] cfg_rdv = 8'h00;
  int         nack_base = 0;

  // Engine + slave model: records strobes, answers with random latency.
  logic [10:0] strobes[$];
  bit          eng_busy = 1'b0;
  int          eng_cnt = 0;
  logic [2:0]  eng_cmd = 3'd0;
  logic        eng_ack = 1'b0;
  int          seg_idx = 0;
  int          nacks_given = 0;

  always @(posedge clk) begin
    m_done_tick <= 1'b0;
    if (reset) begin
      m_ready  <= 1'b1;
      eng_busy <= 1'b0;
      seg_idx  <= 0;
    end else if (m_wr) begin
      strobes.push_back({m_cmd, m_din});
      m_ready  <= 1'b0;
      eng_busy <= 1'b1;
      eng_cnt  <= int'($urandom_range(0, 3));
      eng_cmd  <= m_cmd;
      eng_ack  <= 1'b0;
      if (m_cmd == C_START || m_cmd == C_RESTART) seg_idx <= 0;
      else if (m_cmd == C_WR) begin
        if (seg_idx == 0 && (nacks_given - nack_base) < cfg_nacks) begin
          eng_ack     <= 1'b1;
          nacks_given <= nacks_given + 1;
        end else if (seg_idx == 2 && cfg_dnack) eng_ack <= 1'b1;
        seg_idx <= seg_idx + 1;
      end
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        m_ready  <= 1'b1;
        if (eng_cmd == C_WR || eng_cmd == C_RD) begin
          m_done_tick <= 1'b1;
          m_ack       <= eng_ack;
          m_dout      <= (eng_cmd == C_RD) ? cfg_rdv : 8'($urandom);
        end
      end else eng_cnt <= eng_cnt - 1;
    end
  end

  // Reference model: expected command stream straight from the transaction rules.
  logic [10:0] exp_q[$];
  logic [7:0]  model_rdata = 8'h00;
  int          exp_base = 0;

  function automatic bit build_exp(input vec_t v);
    int budget, tries;
    bit nack, fin;
    budget = v.nacks; tries = 0; nack = 1'b0; fin = 1'b0;
    exp_q.delete();
    while (!fin) begin
      exp_q.push_back({C_START, 8'h00});
      exp_q.push_back({C_WR, v.dev, 1'b0});
      if (budget > 0) begin
        budget--;
        if (tries < MAXR) tries++;
        else begin nack = 1'b1; fin = 1'b1; end
      end else begin
        exp_q.push_back({C_WR, v.rg});
        if (!v.rw) begin
          exp_q.push_back({C_WR, v.wd});
          nack = v.dnack;
          fin  = 1'b1;
        end else begin
          exp_q.push_back({C_RESTART, 8'h00});
          exp_q.push_back({C_WR, v.dev, 1'b1});
          if (budget > 0) begin
            budget--;
            if (tries < MAXR) tries++;
            else begin nack = 1'b1; fin = 1'b1; end
          end else begin
            exp_q.push_back({C_RD, 8'h01});
            fin = 1'b1;
          end
        end
      end
      exp_q.push_back({C_STOP, 8'h00});
    end
    return nack;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    cfg_nacks = v.nacks; cfg_dnack = v.dnack; cfg_rdv = v.rdv;
    nack_base = nacks_given;
    exp_base  = strobes.size();
    rw = v.rw; dev_addr = v.dev; reg_addr = v.rg; wdata = v.wd;
  endtask

  task automatic wait_done(input bit poke);
    int cyc;
    bit ok;
    cyc = 0; ok = 1'b0;
    while (cyc < 3000) begin
      if (done_tick) begin ok = 1'b1; break; end
      if (poke && cyc == 2) begin
        start = 1'b1; rw = ~rw; dev_addr = 7'h7f; reg_addr = ~reg_addr; wdata = ~wdata;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(ok), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
  endtask

  task automatic check_txn(input vec_t v, input string tag);
    bit en;
    int n;
    en = build_exp(v);
    n  = strobes.size() - exp_base;
    chk({tag, "_nstrobe"}, n, exp_q.size());
    if (n == exp_q.size())
      for (int i = 0; i < n; i++)
        chk({tag, "_strobe"}, 32'(strobes[exp_base + i]), 32'(exp_q[i]));
    if (v.rw && !en) model_rdata = v.rdv;
    chk({tag, "_nack"}, 32'(nack_err), 32'(en));
    chk({tag, "_rdata"}, 32'(rdata), 32'(model_rdata));
  endtask

  task automatic run_txn(input vec_t v, input bit poke, input string tag);
    @(negedge clk);
    set_inputs(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_n1"}, 32'(busy), 32'd1);
    wait_done(poke);
    check_txn(v, tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_tick), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 8'h00,  5, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 7'h50, 8'h20, 8'h00, 0, 1'b0, 8'h3C,  7, 1'b0, 8'h3C};
    tbl[2] = '{1'b0, 7'h50, 8'h10, 8'hA5, 2, 1'b0, 8'h00, 11, 1'b0, 8'h3C};
    tbl[3] = '{1'b1, 7'h50, 8'h20, 8'h00, 7, 1'b0, 8'h55,  9, 1'b1, 8'h3C};
    tbl[4] = '{1'b0, 7'h50, 8'h11, 8'h5A, 0, 1'b1, 8'h00,  5, 1'b1, 8'h3C};
    tbl[5] = '{1'b1, 7'h2A, 8'hFF, 8'h00, 1, 1'b0, 8'hC3, 10, 1'b0, 8'hC3};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_nack", 32'(nack_err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_m_wr", 32'(m_wr), 32'd0);
    chk("rst_m_cmd", 32'(m_cmd), 32'(C_STOP));
    chk("rst_m_din", 32'(m_din), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], (i == 2), $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_n", i), strobes.size() - exp_base, tbl[i].exp_n);
      chk($sformatf("tbl%0d_enack", i), 32'(nack_err), 32'(tbl[i].exp_nack));
      chk($sformatf("tbl%0d_erdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
    end

    // start during the done_tick cycle is ignored; the next cycle it is accepted
    v = '{1'b1, 7'h33, 8'h44, 8'h00, 0, 1'b0, 8'h9E, 7, 1'b0, 8'h00};
    @(negedge clk);
    set_inputs(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);
    check_txn(v, "b2b_a");
    start = 1'b1;
    @(negedge clk);
    chk("b2b_ignored_at_done", 32'(busy), 32'd0);
    v = '{1'b0, 7'h12, 8'h34, 8'h56, 0, 1'b0, 8'h00, 5, 1'b0, 8'h00};
    set_inputs(v);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted_next", 32'(busy), 32'd1);
    wait_done(1'b0);
    check_txn(v, "b2b_b");

    for (int i = 0; i < 25; i++) begin
      v.rw    = 1'($urandom);
      v.dev   = 7'($urandom);
      v.rg    = 8'($urandom);
      v.wd    = 8'($urandom);
      v.nacks = int'($urandom_range(0, 4));
      v.dnack = ($urandom_range(0, 3) == 0);
      v.rdv   = 8'($urandom);
      run_txn(v, 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset while waiting on the register byte: immediate return to reset values.
    v = '{1'b0, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 8'h00, 5, 1'b0, 8'h00};
    @(negedge clk);
    set_inputs(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (strobes.size() < exp_base + 3 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_mid_reached_step2", strobes.size() - exp_base, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 8'h00;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_done", 32'(done_tick), 32'd0);
    chk("rstm_nack", 32'(nack_err), 32'd0);
    chk("rstm_rdata", 32'(rdata), 32'd0);
    chk("rstm_m_wr", 32'(m_wr), 32'd0);
    chk("rstm_m_cmd", 32'(m_cmd), 32'(C_STOP));
    chk("rstm_m_din", 32'(m_din), 32'd0);
    repeat (20) @(negedge clk);
    chk("rstm_no_stop", strobes.size() - exp_base, 3);
    chk("rstm_idle", 32'(busy), 32'd0);

    run_txn(tbl[1], 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
